alu_serial_ctrl: RTL and testbench

- Bit-serial sequencer that computes a WIDTH-bit ALU operation on one 1-bit ALU slice (ainv/binv/2-bit select, carry chain), one bit per clock, LSB first.
- Latches operands and a 4-bit op on a start pulse and drives the slice controls each cycle.
- Registers the carry between bits, fixes up set-less-than after the MSB, and reports result plus flags with a one-cycle done pulse.
- Area-minimal alternative to the 32-slice ripple ALU, for control paths that are not throughput-critical.

---
 rtl/alu_serial_ctrl_if.sv | 35 +++
 rtl/alu_serial_ctrl.sv | 122 ++++++++++++
 tb/tb_alu_serial_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_serial_ctrl_if.sv
// Request/result bus of the bit-serial ALU sequencer.
// The abort input exists only when ALU_SERIAL_ABORT_EN is defined.
interface alu_serial_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef ALU_SERIAL_ABORT_EN
  logic             abort;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, op, a, b,
`ifdef ALU_SERIAL_ABORT_EN
    output abort,
`endif
    input  busy, done, result, zero, carry_out, overflow
  );

  modport slave (
    input  start, op, a, b,
`ifdef ALU_SERIAL_ABORT_EN
    input  abort,
`endif
    output busy, done, result, zero, carry_out, overflow
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU: one 1-bit slice evaluated LSB first, one bit per clock.
// Optional abort input enabled by defining ALU_SERIAL_ABORT_EN.
module alu_serial_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  alu_serial_ctrl_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [3:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             carry, cin_msb, msb_sum;
  logic             busy_q, done_q, zero_q, carry_out_q, overflow_q;
  logic [WIDTH-1:0] result_q;

  logic             aa_c, bb_c, sum_c, cout_c, bit_c, ovf_c, abort_c;
  logic [WIDTH-1:0] final_c;

`ifdef ALU_SERIAL_ABORT_EN
  assign abort_c = bus.abort;
`else
  assign abort_c = 1'b0;
`endif

  // One ALU slice; the less input is tied low while bits are shifted.
  always_comb begin
    aa_c   = a_sh[0] ^ op_q[3];
    bb_c   = b_sh[0] ^ op_q[2];
    sum_c  = aa_c ^ bb_c ^ carry;
    cout_c = (aa_c & bb_c) | (carry & (aa_c ^ bb_c));
    bit_c  = 1'b0;
    case (op_q[1:0])
      2'b00:   bit_c = aa_c & bb_c;
      2'b01:   bit_c = aa_c | bb_c;
      2'b10:   bit_c = sum_c;
      default: bit_c = 1'b0;
    endcase
  end

  // Set-less-than uses the corrected sign: MSB sum XOR signed overflow.
  always_comb begin
    ovf_c   = cin_msb ^ carry;
    final_c = res_sh;
    if (op_q[1:0] == 2'b11) final_c = WIDTH'(msb_sum ^ ovf_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      res_sh      <= '0;
      op_q        <= '0;
      cnt         <= '0;
      carry       <= 1'b0;
      cin_msb     <= 1'b0;
      msb_sum     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_c && busy_q) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              a_sh   <= bus.a;
              b_sh   <= bus.b;
              op_q   <= bus.op;
              carry  <= bus.op[2];
              cnt    <= '0;
              busy_q <= 1'b1;
              state  <= RUN;
            end
          end
          RUN: begin
            res_sh <= {bit_c, res_sh[WIDTH-1:1]};
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= cout_c;
            if (cnt == CW'(WIDTH - 1)) begin
              msb_sum <= sum_c;
              cin_msb <= carry;
              state   <= FINISH;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          FINISH: begin
            result_q    <= final_c;
            zero_q      <= (final_c == '0);
            carry_out_q <= carry;
            overflow_q  <= ovf_c;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl (WIDTH=32) with hand-computed results.
module tb_alu_serial_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;
  int   seen;

  alu_serial_ctrl_if #(.WIDTH(32)) bus ();

  alu_serial_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op; inputs are scrambled after acceptance to prove they were latched.
  task automatic do_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input int poke_at, output int cycles);
    bus.op = o; bus.a = av; bus.b = bv; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 4'b0000; bus.a = ~av; bus.b = ~bv;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    cycles = 0;
    while (!bus.done && cycles < 100) begin
      bus.start = (cycles == poke_at);
      @(posedge clk); #1;
      cycles++;
    end
    bus.start = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [31:0] r, input logic z,
                           input logic c, input logic v, input logic chk_flags);
    check({tag, "_lat"}, 32'(lat), 32'd33);
    check({tag, "_res"}, bus.result, r);
    check({tag, "_zero"}, 32'(bus.zero), 32'(z));
    if (chk_flags) begin
      check({tag, "_cout"}, 32'(bus.carry_out), 32'(c));
      check({tag, "_ovf"}, 32'(bus.overflow), 32'(v));
    end
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
`ifdef ALU_SERIAL_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd0);
    check("rst_cout", 32'(bus.carry_out), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);

    do_op(4'b0010, 32'h5, 32'h3, -1, lat);
    check_res("add", 32'h8, 1'b0, 1'b0, 1'b0, 1'b1);
    check("done_cycle_busy", 32'(bus.busy), 32'd0);
    // Back-to-back: this start lands in the done cycle.
    do_op(4'b0110, 32'h7, 32'h7, -1, lat);
    check_res("sub0", 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    do_op(4'b0010, 32'h7FFF_FFFF, 32'h1, -1, lat);
    check_res("ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    do_op(4'b0111, 32'hFFFF_FFFF, 32'h1, -1, lat);
    check_res("slt_neg", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(4'b0111, 32'h5, 32'h3, -1, lat);
    check_res("slt_pos", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(4'b1100, 32'hF0F0_F0F0, 32'h0F0F_0000, -1, lat);
    check_res("nor", 32'h0000_0F0F, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(4'b0001, 32'h0F0F_0000, 32'h0000_00F0, -1, lat);
    check_res("or", 32'h0F0F_00F0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, -1, lat);
    check_res("and", 32'h0F00_0F00, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(4'b0010, 32'h100, 32'h23, 5, lat);
    check_res("add_poke", 32'h123, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("done_pulse_len", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Overflow result is loaded so the reset clearing is observable.
    do_op(4'b0010, 32'h7FFF_FFFF, 32'h1, -1, lat);
    bus.op = 4'b0110; bus.a = 32'h9; bus.b = 32'h4; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    check("midrst_ovf", 32'(bus.overflow), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'd0);

`ifdef ALU_SERIAL_ABORT_EN
    do_op(4'b0010, 32'h5, 32'h3, -1, lat);
    bus.op = 4'b1100; bus.a = 32'h0; bus.b = 32'h0; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_result", bus.result, 32'h8);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
